// File: rtl/fsm_unlock_ctrl.sv
// Key-locked FSM sequencer: serial key load, LFSR/MISR self-check challenge,
// then user pass-through on a signature match or lockout after repeated failures.
module fsm_unlock_ctrl #(
  parameter int          KEY_W      = 8,
  parameter int          CHK_CYCLES = 64,
  parameter logic [4:0]  LFSR_SEED  = 5'h15,
  parameter logic [24:0] EXP_SIG    = 25'h0,
  parameter int          MAX_TRIES  = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             key_start,
  input  logic             key_bit,
  input  logic             key_valid,
  input  logic [4:0]       user_x,
  input  logic [24:0]      fsm_y,
  output logic             fsm_rst,
  output logic [4:0]       fsm_x,
  output logic [KEY_W-1:0] fsm_key,
  output logic [24:0]      y_out,
  output logic             unlocked,
  output logic             lockout,
  output logic             busy,
  output logic [1:0]       fail_cnt
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_RST, S_CHECK, S_CMP, S_FAIL, S_UNLOCKED, S_LOCKOUT
  } state_t;

  localparam int BIT_W = (KEY_W > 1) ? $clog2(KEY_W) : 1;
  localparam int CYC_W = $clog2(CHK_CYCLES);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(KEY_W - 1);
  localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(CHK_CYCLES - 1);
  localparam logic [CYC_W-1:0] CYC_ONE  = CYC_W'(1);
  localparam logic [1:0]       TRIES    = 2'(MAX_TRIES);

  state_t           r_state;
  state_t           w_next;
  logic [KEY_W-1:0] r_key;
  logic [BIT_W-1:0] r_bit_cnt;
  logic [CYC_W-1:0] r_cyc_cnt;
  logic [4:0]       r_lfsr;
  logic [24:0]      r_misr;
  logic [1:0]       r_fail_cnt;
  logic             r_fsm_rst;
  logic [4:0]       r_fsm_x;
  logic             r_unlocked;
  logic             r_lockout;
  logic             r_busy;

  logic             w_start;
  logic             w_sig_ok;
  logic             w_last_try;
  logic [4:0]       w_lfsr_next;
  logic [24:0]      w_misr_next;

  // key_start is honoured only where a new load makes sense; aborting a
  // running challenge this way would let a wrong key dodge the fail count.
  assign w_start     = key_start && (r_state inside {S_IDLE, S_LOAD, S_FAIL, S_UNLOCKED});
  assign w_lfsr_next = {r_lfsr[3:0], r_lfsr[4] ^ r_lfsr[2]};
  assign w_misr_next = {r_misr[23:0], r_misr[24] ^ r_misr[21]} ^ fsm_y;
  assign w_sig_ok    = (r_misr == EXP_SIG);
  assign w_last_try  = ((r_fail_cnt + 2'd1) == TRIES);

  always_comb begin
    // NOTE: default assignment first so no path leaves w_next unassigned (no latch).
    w_next = r_state;
    case (r_state)
      S_IDLE, S_FAIL, S_UNLOCKED: if (w_start) w_next = S_LOAD;
      S_LOAD: begin
        if (w_start)                                 w_next = S_LOAD;
        else if (key_valid && r_bit_cnt == BIT_LAST) w_next = S_RST;
      end
      S_RST:     if (r_cyc_cnt == CYC_ONE)  w_next = S_CHECK;
      S_CHECK:   if (r_cyc_cnt == CYC_LAST) w_next = S_CMP;
      S_CMP:     w_next = w_sig_ok ? S_UNLOCKED : (w_last_try ? S_LOCKOUT : S_FAIL);
      S_LOCKOUT: w_next = S_LOCKOUT;
      default:   w_next = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they are registered and
  // change in the same edge as the state itself.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
      r_state    <= S_IDLE;
      r_key      <= '0;
      r_bit_cnt  <= '0;
      r_cyc_cnt  <= '0;
      r_lfsr     <= LFSR_SEED;
      r_misr     <= '0;
      r_fail_cnt <= '0;
      r_fsm_rst  <= 1'b1;
      r_fsm_x    <= '0;
      r_unlocked <= 1'b0;
      r_lockout  <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_fsm_rst  <= !(w_next inside {S_CHECK, S_UNLOCKED});
      r_busy     <= (w_next inside {S_LOAD, S_RST, S_CHECK, S_CMP});
      r_unlocked <= (w_next == S_UNLOCKED);
      r_lockout  <= (w_next == S_LOCKOUT);

      if (w_next == S_CHECK)
        r_fsm_x <= (r_state == S_CHECK) ? w_lfsr_next : LFSR_SEED;
      else if (w_next == S_UNLOCKED)
        r_fsm_x <= user_x;
      else
        r_fsm_x <= '0;

      if (w_start) begin
        r_key     <= '0;
        r_bit_cnt <= '0;
        // Retries from FAIL keep counting; only a fresh session clears it.
        if (r_state inside {S_IDLE, S_UNLOCKED}) r_fail_cnt <= '0;
      end else begin
        case (r_state)
          S_LOAD: if (key_valid) begin
            r_key     <= {r_key[KEY_W-2:0], key_bit};
            r_bit_cnt <= (r_bit_cnt == BIT_LAST) ? '0 : r_bit_cnt + BIT_W'(1);
          end
          S_RST: begin
            r_lfsr    <= LFSR_SEED;
            r_misr    <= '0;
            r_cyc_cnt <= (r_cyc_cnt == CYC_ONE) ? '0 : r_cyc_cnt + CYC_W'(1);
          end
          S_CHECK: begin
            r_lfsr    <= w_lfsr_next;
            r_misr    <= w_misr_next;
            r_cyc_cnt <= (r_cyc_cnt == CYC_LAST) ? '0 : r_cyc_cnt + CYC_W'(1);
          end
          S_CMP: if (!w_sig_ok) begin
            r_fail_cnt <= r_fail_cnt + 2'd1;
            r_key      <= '0;
          end
          default: ;
        endcase
      end
    end
  end

  assign fsm_rst  = r_fsm_rst;
  assign fsm_x    = r_fsm_x;
  assign fsm_key  = r_key;
  assign unlocked = r_unlocked;
  assign lockout  = r_lockout;
  assign busy     = r_busy;
  assign fail_cnt = r_fail_cnt;
  assign y_out    = r_unlocked ? fsm_y : '0;

endmodule

// File: tb/tb_fsm_unlock_ctrl.sv
// Bench for fsm_unlock_ctrl: a keyed toy FSM answers the challenge, and the
// golden signature, stimulus sequence and latencies come from arithmetic models.
module tb_fsm_unlock_ctrl;

  localparam logic [4:0] SEED       = 5'h15;
  localparam logic [7:0] GOOD_KEY   = 8'hA5;
  localparam int         CHK        = 64;
  localparam int         TRIES      = 3;
  localparam int         UNLOCK_LAT = 1 + 8 + 2 + CHK + 1;
  localparam logic [43:0] RST_VAL   = {1'b1, 43'd0};

  function automatic logic [4:0] lfsr_step(input logic [4:0] q);
    int v;
    v = int'(q);
    return 5'(((v * 2) % 32) + (((v >> 4) ^ (v >> 2)) & 1));
  endfunction

  function automatic logic [24:0] misr_step(input logic [24:0] m, input logic [24:0] y);
    int v;
    v = int'(m);
    return 25'(((v * 2) % 33554432) + (((v >> 24) ^ (v >> 21)) & 1)) ^ y;
  endfunction

  function automatic logic [4:0] toy_next(input logic [4:0] s, input logic [4:0] x, input logic [7:0] k);
    return 5'((int'(s) * 3 + int'(x) + int'(k)) % 32);
  endfunction

  function automatic logic [24:0] toy_out(input logic [4:0] s, input logic [4:0] x, input logic [7:0] k);
    logic [4:0] kh;
    logic [4:0] kl;
    kh = k[7:3];
    kl = k[4:0];
    return {s, x ^ kl, 5'(int'(s) + int'(x)), kh ^ s, 5'(int'(s) * int'(x) + int'(k))};
  endfunction

  function automatic logic [24:0] golden_sig(input logic [7:0] k);
    logic [4:0]  s;
    logic [4:0]  x;
    logic [24:0] m;
    s = '0;
    x = SEED;
    m = '0;
    for (int i = 0; i < CHK; i++) begin
      m = misr_step(m, toy_out(s, x, k));
      s = toy_next(s, x, k);
      x = lfsr_step(x);
    end
    return m;
  endfunction

  localparam logic [24:0] GOLD = golden_sig(GOOD_KEY);

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        key_start = 1'b0;
  logic        key_bit = 1'b0;
  logic        key_valid = 1'b0;
  logic [4:0]  user_x = '0;
  logic [24:0] fsm_y;
  logic        fsm_rst;
  logic [4:0]  fsm_x;
  logic [7:0]  fsm_key;
  logic [24:0] y_out;
  logic        unlocked;
  logic        lockout;
  logic        busy;
  logic [1:0]  fail_cnt;
  logic [4:0]  toy_s = '0;

  int n_pass  = 0;
  int n_total = 0;

  fsm_unlock_ctrl #(
    .KEY_W(8), .CHK_CYCLES(CHK), .LFSR_SEED(SEED), .EXP_SIG(GOLD), .MAX_TRIES(TRIES)
  ) dut (
    .clk(clk), .rst(rst), .key_start(key_start), .key_bit(key_bit), .key_valid(key_valid),
    .user_x(user_x), .fsm_y(fsm_y), .fsm_rst(fsm_rst), .fsm_x(fsm_x), .fsm_key(fsm_key),
    .y_out(y_out), .unlocked(unlocked), .lockout(lockout), .busy(busy), .fail_cnt(fail_cnt)
  );

  always #5 clk = ~clk;

  // Toy keyed FSM standing in for the controlled design.
  always @(posedge clk) begin
    if (fsm_rst) toy_s <= '0;
    else         toy_s <= toy_next(toy_s, fsm_x, fsm_key);
  end
  assign fsm_y = toy_out(toy_s, fsm_x, fsm_key);

  function automatic logic [43:0] outs();
    return {fsm_rst, fsm_x, fsm_key, y_out, unlocked, lockout, busy, fail_cnt};
  endfunction

  task automatic start(inout int n);
    key_start = 1'b1;
    @(negedge clk); n++;
    key_start = 1'b0;
  endtask

  task automatic send_bits(input logic [7:0] k, input int max_gap, inout int n);
    for (int b = 7; b >= 0; b--) begin
      int gap;
      gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
      repeat (gap) begin
        key_valid = 1'b0; key_bit = 1'($urandom);
        @(negedge clk); n++;
      end
      key_valid = 1'b1; key_bit = k[b];
      @(negedge clk); n++;
    end
    key_valid = 1'b0;
  endtask

  task automatic run_check(inout int n);
    logic [4:0] x;
    int  chk;
    bit  done;
    x = SEED; chk = 0; done = 1'b0;
    for (int i = 0; i < 300 && !done; i++) begin
      @(negedge clk); n++;
      if (!busy) done = 1'b1;
      else if (!fsm_rst) begin
        n_total++;
        if (fsm_x !== x) $display("FAIL chk_stim[%0d]: fsm_x=%h want %h", chk, fsm_x, x);
        else n_pass++;
        x = lfsr_step(x);
        chk++;
      end
    end
    n_total++;
    if (!done) $display("FAIL chk_timeout: busy still 1 after %0d clocks, want 0", n); else n_pass++;
    n_total++;
    if (chk != CHK) $display("FAIL chk_len: %0d challenge clocks, want %0d", chk, CHK); else n_pass++;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    @(negedge clk);
    n_total++;
    if (outs() !== RST_VAL) $display("FAIL reset_vals: got %h want %h", outs(), RST_VAL); else n_pass++;
    rst = 1'b1; key_valid = 1'b1; key_bit = 1'b1;
    @(negedge clk);
    key_valid = 1'b0;
    n_total++;
    if (outs() !== RST_VAL) $display("FAIL idle_vals: got %h want %h", outs(), RST_VAL); else n_pass++;
  endtask

  task automatic test_load();
    int n;
    logic [7:0] k;
    logic [7:0] exp_key;
    n = 0; k = GOOD_KEY; exp_key = '0;
    start(n);
    n_total++;
    if ({fsm_rst, busy, fsm_key} !== {1'b1, 1'b1, 8'h00})
      $display("FAIL load_enter: rst/busy/key=%b%b/%h want 11/00", fsm_rst, busy, fsm_key);
    else n_pass++;
    for (int b = 7; b >= 0; b--) begin
      key_valid = 1'b1; key_bit = k[b];
      @(negedge clk); n++;
      exp_key = 8'((int'(exp_key) * 2 + int'(k[b])) % 256);
      n_total++;
      if (fsm_key !== exp_key) $display("FAIL load_shift[%0d]: fsm_key=%h want %h", b, fsm_key, exp_key);
      else n_pass++;
    end
    key_valid = 1'b0;
    n_total++;
    if ({fsm_rst, busy, unlocked} !== 3'b110) $display("FAIL rst_phase1: rst/busy/unl=%b%b%b want 110", fsm_rst, busy, unlocked);
    else n_pass++;
    @(negedge clk); n++;
    n_total++;
    if ({fsm_rst, fsm_x} !== {1'b1, 5'd0}) $display("FAIL rst_phase2: fsm_rst=%b fsm_x=%h want 1/00", fsm_rst, fsm_x);
    else n_pass++;
    run_check(n);
    n_total++;
    if (n != UNLOCK_LAT) $display("FAIL unlock_latency: %0d clocks want %0d", n, UNLOCK_LAT); else n_pass++;
    n_total++;
    if ({unlocked, fsm_rst, busy, fail_cnt, fsm_key} !== {1'b1, 1'b0, 1'b0, 2'd0, GOOD_KEY})
      $display("FAIL unlock_state: unl/rst/busy/fc/key=%b%b%b/%0d/%h want 100/0/%h", unlocked, fsm_rst, busy, fail_cnt, fsm_key, GOOD_KEY);
    else n_pass++;
  endtask

  task automatic test_passthrough();
    logic [4:0] ux;
    for (int i = 0; i < 7; i++) begin
      ux = (i == 0) ? 5'b11011 : 5'($urandom);
      user_x = ux; key_valid = 1'($urandom); key_bit = 1'($urandom);
      @(negedge clk);
      n_total++;
      if (fsm_x !== ux) $display("FAIL pass_x[%0d]: fsm_x=%h want %h", i, fsm_x, ux); else n_pass++;
      n_total++;
      if (y_out !== fsm_y) $display("FAIL pass_y[%0d]: y_out=%h want %h", i, y_out, fsm_y); else n_pass++;
      n_total++;
      if ({unlocked, fsm_key} !== {1'b1, GOOD_KEY}) $display("FAIL pass_hold[%0d]: unl=%b key=%h want 1/%h", i, unlocked, fsm_key, GOOD_KEY);
      else n_pass++;
    end
    key_valid = 1'b0;
  endtask

  task automatic test_relock();
    int n;
    n = 0;
    start(n);
    n_total++;
    if ({unlocked, fsm_rst, busy, fsm_key, y_out} !== {1'b0, 1'b1, 1'b1, 8'h00, 25'd0})
      $display("FAIL relock: unl/rst/busy=%b%b%b key=%h y_out=%h want 011/00/0", unlocked, fsm_rst, busy, fsm_key, y_out);
    else n_pass++;
    send_bits(GOOD_KEY, 0, n);
    run_check(n);
    n_total++;
    if (!(n == UNLOCK_LAT && unlocked === 1'b1)) $display("FAIL relock_unlock: %0d clocks unl=%b want %0d/1", n, unlocked, UNLOCK_LAT);
    else n_pass++;
  endtask

  task automatic test_restart_in_load();
    int n;
    logic [7:0] k;
    n = 0; k = GOOD_KEY;
    start(n);
    for (int b = 7; b >= 4; b--) begin
      key_valid = 1'b1; key_bit = k[b];
      @(negedge clk);
    end
    n_total++;
    if (fsm_key !== 8'h0A) $display("FAIL restart_partial: fsm_key=%h want 0a", fsm_key); else n_pass++;
    key_start = 1'b1; key_valid = 1'b1; key_bit = k[3];
    @(negedge clk);
    key_start = 1'b0; key_valid = 1'b0;
    n = 1;
    n_total++;
    if ({fsm_key, busy} !== {8'h00, 1'b1}) $display("FAIL restart_clear: key=%h busy=%b want 00/1", fsm_key, busy); else n_pass++;
    send_bits(k, 0, n);
    n_total++;
    if (fsm_key !== k) $display("FAIL restart_key: fsm_key=%h want %h", fsm_key, k); else n_pass++;
    run_check(n);
    n_total++;
    if (!(n == UNLOCK_LAT && unlocked === 1'b1)) $display("FAIL restart_unlock: %0d clocks unl=%b want %0d/1", n, unlocked, UNLOCK_LAT);
    else n_pass++;
  endtask

  task automatic test_abort_check();
    int n;
    n = 0;
    start(n);
    send_bits(GOOD_KEY, 0, n);
    repeat (2 + 30) @(negedge clk);
    n_total++;
    if ({fsm_rst, busy} !== 2'b01) $display("FAIL abort_in_check: rst/busy=%b%b want 01", fsm_rst, busy); else n_pass++;
    rst = 1'b0;
    #1;
    n_total++;
    if (outs() !== RST_VAL) $display("FAIL abort_async: got %h want %h", outs(), RST_VAL); else n_pass++;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_total++;
    if (outs() !== RST_VAL) $display("FAIL abort_idle: got %h want %h", outs(), RST_VAL); else n_pass++;
    n = 0;
    start(n);
    send_bits(GOOD_KEY, 0, n);
    run_check(n);
    n_total++;
    if (!(n == UNLOCK_LAT && unlocked === 1'b1)) $display("FAIL abort_unlock: %0d clocks unl=%b want %0d/1", n, unlocked, UNLOCK_LAT);
    else n_pass++;
  endtask

  task automatic test_random_gaps();
    int n;
    int exp_n;
    for (int r = 0; r < 3; r++) begin
      n = 0;
      user_x = 5'($urandom);
      start(n);
      send_bits(GOOD_KEY, 3, n);
      exp_n = n + 2 + CHK + 1;
      run_check(n);
      n_total++;
      if (n != exp_n) $display("FAIL gap_latency[%0d]: %0d clocks want %0d", r, n, exp_n); else n_pass++;
      n_total++;
      if ({unlocked, fail_cnt} !== {1'b1, 2'd0}) $display("FAIL gap_unlock[%0d]: unl=%b fc=%0d want 1/0", r, unlocked, fail_cnt);
      else n_pass++;
    end
  endtask

  task automatic test_lockout();
    int n;
    int exp_n;
    for (int t = 1; t <= TRIES; t++) begin
      n = 0;
      start(n);
      send_bits(8'h00, 2, n);
      exp_n = n + 2 + CHK + 1;
      run_check(n);
      n_total++;
      if (n != exp_n) $display("FAIL bad_latency[%0d]: %0d clocks want %0d", t, n, exp_n); else n_pass++;
      n_total++;
      if ({fail_cnt, lockout} !== {2'(t), t >= TRIES})
        $display("FAIL bad_count[%0d]: fc=%0d lockout=%b want %0d/%0d", t, fail_cnt, lockout, t, t >= TRIES);
      else n_pass++;
      n_total++;
      if ({unlocked, fsm_rst, fsm_key, busy} !== {1'b0, 1'b1, 8'h00, 1'b0})
        $display("FAIL bad_outs[%0d]: unl/rst=%b%b key=%h busy=%b want 01/00/0", t, unlocked, fsm_rst, fsm_key, busy);
      else n_pass++;
    end
    n = 0;
    start(n);
    n_total++;
    if ({busy, lockout} !== 2'b01) $display("FAIL lock_start: busy/lockout=%b%b want 01", busy, lockout); else n_pass++;
    send_bits(GOOD_KEY, 0, n);
    repeat (4) @(negedge clk);
    n_total++;
    if ({lockout, busy, unlocked, fsm_rst, fsm_key, fail_cnt} !== {1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 2'd3})
      $display("FAIL lock_hold: lk/busy/unl/rst=%b%b%b%b key=%h fc=%0d want 1001/00/3", lockout, busy, unlocked, fsm_rst, fsm_key, fail_cnt);
    else n_pass++;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, want summary");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_load();
    test_passthrough();
    test_relock();
    test_restart_in_load();
    test_abort_check();
    test_random_gaps();
    test_lockout();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
